// File: rtl/m_divider_iter.sv
// Iterative restoring divider with RISC-V div/divu/rem/remu semantics.
// Performs one shift-subtract step per clock on operand magnitudes and fixes
// up result signs at the end. Divide-by-zero and signed overflow bypass the
// iteration and complete in a single busy cycle.
module m_divider_iter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH:0]   rem_reg;    // partial remainder, one guard bit wide
    logic [WIDTH-1:0] quo_reg;    // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_reg;    // divisor magnitude
    logic             neg_q_reg;
    logic             neg_r_reg;

    // Operand decode at the accepting edge
    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic             divisor_zero;
    logic             signed_overflow;
    logic             accept;

    // Iteration step and final sign fix-up
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // Sign/magnitude split of the incoming operands and special-case detection
    always_comb begin
        dividend_neg    = i_signed & i_dividend[WIDTH-1];
        divisor_neg     = i_signed & i_divisor[WIDTH-1];
        dividend_mag    = dividend_neg ? (~i_dividend + 1'b1) : i_dividend;
        divisor_mag     = divisor_neg  ? (~i_divisor  + 1'b1) : i_divisor;
        divisor_zero    = (i_divisor == '0);
        signed_overflow = i_signed && (i_dividend == MIN_NEG) && (i_divisor == '1);
        // A start during the o_valid cycle is dropped so back-to-back
        // requests always see one idle cycle after the result pulse.
        accept          = (state_reg == S_IDLE) && i_start && !o_valid;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        shifted  = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_reg};
        fits     = ~diff[WIDTH];
        rem_next = fits ? diff : shifted;
        quo_next = {quo_reg[WIDTH-2:0], fits};
        // Truncating division: quotient negative when signs differ,
        // remainder carries the dividend's sign.
        q_final  = neg_q_reg ? (~quo_next + 1'b1) : quo_next;
        r_final  = neg_r_reg ? (~rem_next[WIDTH-1:0] + 1'b1) : rem_next[WIDTH-1:0];
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg   <= S_IDLE;
            count_reg   <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            o_busy      <= 1'b0;
            o_valid     <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        o_busy <= 1'b1;
                        if (divisor_zero) begin
                            o_quotient  <= '1;
                            o_remainder <= i_dividend;
                            state_reg   <= S_DONE;
                        end else if (signed_overflow) begin
                            o_quotient  <= i_dividend;
                            o_remainder <= '0;
                            state_reg   <= S_DONE;
                        end else begin
                            rem_reg   <= '0;
                            quo_reg   <= dividend_mag;
                            dvs_reg   <= divisor_mag;
                            neg_q_reg <= dividend_neg ^ divisor_neg;
                            neg_r_reg <= dividend_neg;
                            count_reg <= '0;
                            state_reg <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    if (count_reg == LAST_COUNT) begin
                        count_reg   <= '0;
                        o_quotient  <= q_final;
                        o_remainder <= r_final;
                        state_reg   <= S_DONE;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    // Results are already stable; the pulse is raised as the
                    // block goes idle so it can never overlap a new operation.
                    o_busy    <= 1'b0;
                    o_valid   <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: begin
                    o_busy    <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_divider_iter.sv
// Directed bench for m_divider_iter: vector table plus hand-written sequences
// for busy-start, start-during-valid and reset-mid-run.
module tb_m_divider_iter;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sgn;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic         busy;
    logic         valid;
    logic [W-1:0] quo;
    logic [W-1:0] rem;

    int n_cmp  = 0;
    int n_fail = 0;

    m_divider_iter #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_signed    (sgn),
        .i_dividend  (dvd),
        .i_divisor   (dvs),
        .o_busy      (busy),
        .o_valid     (valid),
        .o_quotient  (quo),
        .o_remainder (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Wait for o_valid, sampling 1 time unit after each rising edge; returns edges elapsed.
    task automatic wait_valid(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = busy ? 1 : 0;
        while (!valid && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (busy) busy_cycles++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int edges, bc;
        @(negedge clk);
        start = 1'b1; sgn = v.s; dvd = v.a; dvs = v.b;
        @(posedge clk); #1;
        start = 1'b0;
        // scramble operands after acceptance to prove they were captured
        dvd = $urandom; dvs = $urandom; sgn = ~v.s;
        wait_valid(edges, bc);
        check($sformatf("v%0d latency", idx), W'(edges), W'(v.lat));
        check($sformatf("v%0d busy_cycles", idx), W'(bc), W'(v.lat));
        check($sformatf("v%0d quotient", idx), quo, v.q);
        check($sformatf("v%0d remainder", idx), rem, v.r);
        check($sformatf("v%0d busy_in_valid", idx), W'(busy), W'(0));
        $display("vec %0d: s=%0d 0x%08h / 0x%08h -> q=0x%08h r=0x%08h after %0d edges",
                 idx, v.s, v.a, v.b, quo, rem, edges);
        @(posedge clk); #1;
        check($sformatf("v%0d valid_pulse", idx), W'(valid), W'(0));
    endtask

    vec_t vecs[16];

    initial begin
        int edges, bc, pulses;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFD,   32'hFFFFFFFF,   33};
        vecs[2]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   32'hFFFFFFFD,   32'h00000001,   33};
        vecs[3]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1};
        vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1};
        vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h0,          1};
        vecs[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h0,          32'h80000000,   33};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'h0,          33};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'h0,          33};
        vecs[9]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   33};
        vecs[10] = '{1'b0, 32'd7,          32'd9,          32'd0,          32'd7,          33};
        vecs[11] = '{1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'h0,          33};
        vecs[12] = '{1'b1, 32'h80000000,   32'd2,          32'hC0000000,   32'h0,          33};
        vecs[13] = '{1'b0, 32'h12345678,   32'h00001000,   32'h00012345,   32'h00000678,   33};
        vecs[14] = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1};
        vecs[15] = '{1'b0, 32'hFFFFFFFE,   32'hFFFFFFFF,   32'h0,          32'hFFFFFFFE,   33};

        rst = 1'b1; start = 1'b0; sgn = 1'b0; dvd = '0; dvs = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", W'(busy), W'(0));
        check("reset valid", W'(valid), W'(0));
        check("reset quotient", quo, '0);
        check("reset remainder", rem, '0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Start while busy: second request at cycle 10 of a run must be ignored.
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; dvd = 32'd100; dvs = 32'd7;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; dvd = 32'd50; dvs = 32'd5;
        @(negedge clk); start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (valid) begin
                pulses++;
                check("busy_start quotient", quo, 32'd14);
                check("busy_start remainder", rem, 32'd2);
            end
        end
        check("busy_start pulses", W'(pulses), W'(1));
        check("busy_start idle", W'(busy), W'(0));
        $display("seq busy_start: q=0x%08h r=0x%08h pulses=%0d", quo, rem, pulses);

        // Start asserted in the o_valid cycle is ignored; accepted one cycle later.
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; dvd = 32'd100; dvs = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(edges, bc);
        check("valid_start first latency", W'(edges), W'(33));
        start = 1'b1; dvd = 32'd20; dvs = 32'd3;
        @(posedge clk); #1;
        check("valid_start ignored", W'(busy), W'(0));
        @(posedge clk); #1;
        check("valid_start accepted", W'(busy), W'(1));
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("hold quotient while busy", quo, 32'd14);
        check("hold remainder while busy", rem, 32'd2);
        wait_valid(edges, bc);
        check("valid_start quotient", quo, 32'd6);
        check("valid_start remainder", rem, 32'd2);
        $display("seq valid_start: q=0x%08h r=0x%08h", quo, rem);
        @(posedge clk); #1;

        // Reset mid-run at cycle 15, then a start on the first edge after reset.
        @(negedge clk);
        start = 1'b1; sgn = 1'b1; dvd = 32'hFFFFFFF9; dvs = 32'd2;
        @(negedge clk); start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (valid) pulses++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        if (valid) pulses++;
        check("midreset busy", W'(busy), W'(0));
        check("midreset valid", W'(valid), W'(0));
        check("midreset quotient", quo, '0);
        check("midreset remainder", rem, '0);
        @(negedge clk);
        rst = 1'b0; start = 1'b1; sgn = 1'b0; dvd = 32'd100; dvs = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        check("postreset accepted", W'(busy), W'(1));
        wait_valid(edges, bc);
        check("midreset no pulse", W'(pulses), W'(0));
        check("postreset latency", W'(edges), W'(33));
        check("postreset quotient", quo, 32'd14);
        check("postreset remainder", rem, 32'd2);
        $display("seq midreset: q=0x%08h r=0x%08h after %0d edges", quo, rem, edges);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
